// File: rtl/otp_ctrl_edn_gather_pkg.sv
// Shared widths, requestor indices and the sparse state encoding for the EDN gather front-end.
package otp_ctrl_edn_gather_pkg;

  localparam int unsigned NumEdnReq    = 2;
  localparam int unsigned EdnBusWidth  = 32;
  localparam int unsigned EdnDataWidth = 64;
  localparam int unsigned NumWords     = EdnDataWidth / EdnBusWidth;
  localparam int unsigned WordCntWidth = $clog2(NumWords + 1);
  localparam int unsigned ReqIdxWidth  = (NumEdnReq > 1) ? $clog2(NumEdnReq) : 1;
  localparam int unsigned StateWidth   = 9;

  typedef enum logic [ReqIdxWidth-1:0] {
    EdnReqLfsr = 0,
    EdnReqKey  = 1
  } edn_req_idx_e;

  // Pairwise Hamming distance >= 5; all-zero is deliberately not a legal state.
  typedef enum logic [StateWidth-1:0] {
    IdleSt   = 9'b101100011,
    GatherSt = 9'b010111000,
    AckSt    = 9'b111010110,
    ErrorSt  = 9'b000001101
  } edn_gather_state_e;

  function automatic logic [ReqIdxWidth-1:0] rr_next(logic [ReqIdxWidth-1:0] idx);
    return (idx == ReqIdxWidth'(NumEdnReq - 1)) ? '0 : idx + ReqIdxWidth'(1);
  endfunction

endpackage

// File: rtl/otp_ctrl_edn_gather_if.sv
// Requestor handshake plus EDN word handshake of the gather front-end.
interface otp_ctrl_edn_gather_if
  import otp_ctrl_edn_gather_pkg::*;
();

  logic [NumEdnReq-1:0]    req;
  logic [NumEdnReq-1:0]    ack;
  logic [EdnDataWidth-1:0] data;
  logic                    edn_req;
  logic                    edn_ack;
  logic [EdnBusWidth-1:0]  edn_bus;

  modport slave (
    input  req,
    input  edn_ack,
    input  edn_bus,
    output ack,
    output data,
    output edn_req
  );

  modport master (
    output req,
    output edn_ack,
    output edn_bus,
    input  ack,
    input  data,
    input  edn_req
  );

endinterface

// File: rtl/otp_ctrl_edn_rr_arb.sv
// Round-robin requestor pick: first set request at or above rr_ptr, wrapping around.
module otp_ctrl_edn_rr_arb
  import otp_ctrl_edn_gather_pkg::*;
(
  input  logic [NumEdnReq-1:0]   req_i,
  input  logic [ReqIdxWidth-1:0] rr_ptr,
  output logic [NumEdnReq-1:0]   gnt_o
);

  int unsigned idx;
  logic        found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NumEdnReq; i++) begin
      idx = (32'(rr_ptr) + i) % NumEdnReq;
      if (!found && req_i[ReqIdxWidth'(idx)]) begin
        gnt_o[ReqIdxWidth'(idx)] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/otp_ctrl_edn_gather.sv
// Gathers NumWords EDN bus words into one entropy word and hands it to a round-robin
// selected requestor; one EDN transaction in flight at a time.
module otp_ctrl_edn_gather
  import otp_ctrl_edn_gather_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  otp_ctrl_edn_gather_if.slave bus,
  output logic                 fsm_err_o
);

  edn_gather_state_e       state_q, state_d;
  logic [ReqIdxWidth-1:0]  grant_q, grant_d;
  logic [ReqIdxWidth-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ReqIdxWidth-1:0]  gnt_idx;
  logic [WordCntWidth-1:0] word_cnt_q, word_cnt_d;
  logic [EdnDataWidth-1:0] data_q, data_d, data_out_q;
  logic [NumEdnReq-1:0]    gnt, ack_d, ack_q;
  logic                    lost_q, lost_d;
  logic                    edn_req_d, edn_req_q;

  otp_ctrl_edn_rr_arb u_arb (
    .req_i  (bus.req),
    .rr_ptr (rr_ptr_q),
    .gnt_o  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NumEdnReq; i++) begin
      if (gnt[i]) gnt_idx = ReqIdxWidth'(i);
    end
  end

  // Next state plus next values of the registered outputs.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    word_cnt_d = word_cnt_q;
    data_d     = data_q;
    lost_d     = lost_q;
    ack_d      = '0;
    edn_req_d  = 1'b0;
    fsm_err_o  = 1'b0;

    unique case (state_q)
      IdleSt: begin
        if (|bus.req) begin
          grant_d    = gnt_idx;
          word_cnt_d = '0;
          lost_d     = 1'b0;
          edn_req_d  = 1'b1;
          state_d    = GatherSt;
        end
      end

      GatherSt: begin
        edn_req_d = 1'b1;
        // A requestor that lets go mid-gather forfeits this word.
        if (!bus.req[grant_q]) lost_d = 1'b1;
        if (bus.edn_ack) begin
          for (int unsigned w = 0; w < NumWords; w++) begin
            if (word_cnt_q == WordCntWidth'(w)) data_d[w*EdnBusWidth +: EdnBusWidth] = bus.edn_bus;
          end
          word_cnt_d = word_cnt_q + WordCntWidth'(1);
          if (word_cnt_q == WordCntWidth'(NumWords - 1)) begin
            edn_req_d      = 1'b0;
            ack_d[grant_q] = ~lost_d;
            state_d        = AckSt;
          end
        end
      end

      AckSt: begin
        data_d   = '0;
        rr_ptr_d = rr_next(grant_q);
        state_d  = IdleSt;
      end

      ErrorSt: begin
        fsm_err_o = 1'b1;
      end

      default: begin
        fsm_err_o = 1'b1;
        state_d   = ErrorSt;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IdleSt;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      word_cnt_q <= '0;
      data_q     <= '0;
      lost_q     <= 1'b0;
      ack_q      <= '0;
      data_out_q <= '0;
      edn_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      word_cnt_q <= word_cnt_d;
      data_q     <= data_d;
      lost_q     <= lost_d;
      ack_q      <= ack_d;
      data_out_q <= (|ack_d) ? data_d : '0;
      edn_req_q  <= edn_req_d;
    end
  end

  assign bus.ack     = ack_q;
  assign bus.data    = data_out_q;
  assign bus.edn_req = edn_req_q;

  WidthMultiple_A: assert property (@(posedge clk_i) (EdnDataWidth % EdnBusWidth) == 0);

  AckOnehot0_A: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.ack));

  DataZeroNoAck_A: assert property (@(posedge clk_i) disable iff (rst_i)
    !(|bus.ack) |-> (bus.data == '0));

  EdnReqInGather_A: assert property (@(posedge clk_i) disable iff (rst_i || fsm_err_o)
    bus.edn_req |-> (state_q == GatherSt));

endmodule

// File: tb/tb_otp_ctrl_edn_gather.sv
// Directed plus randomized checks of the EDN gather front-end against a transaction-level model.
module tb_otp_ctrl_edn_gather;
  import otp_ctrl_edn_gather_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;
  logic fsm_err_o;

  otp_ctrl_edn_gather_if bus_if ();

  otp_ctrl_edn_gather dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus       (bus_if),
    .fsm_err_o (fsm_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp    = 0;
  int n_fail   = 0;
  int ptr      = 0;   // model: round-robin start index
  int viol_cnt = 0;
  bit mon_active = 1'b0;
  int mon_g      = 0;

  // Requestor must hold its request from grant to ack.
  always @(posedge clk_i) begin
    if (mon_active && !bus_if.req[mon_g]) viol_cnt <= viol_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction, entered in an idle cycle; returns in the idle cycle after the ack.
  task automatic run_txn(input logic [1:0] reqv, input int s0, input int s1,
                         input logic [31:0] w0, input logic [31:0] w1,
                         input bit drop, input bit hold_req);
    int          g;
    int          stall [2];
    logic [31:0] w [2];
    logic [1:0]  exp_ack;
    logic [63:0] exp_data;
    stall[0] = s0; stall[1] = s1;
    w[0] = w0;     w[1] = w1;
    g = -1;
    for (int i = 0; i < 2; i++) begin
      int k;
      k = (ptr + i) % 2;
      if (g < 0 && reqv[k]) g = k;
    end
    exp_ack  = drop ? 2'b00 : 2'(1 << g);
    exp_data = drop ? 64'h0 : {w1, w0};
    ptr      = (g + 1) % 2;

    bus_if.req     = reqv;
    bus_if.edn_ack = 1'b0;
    check("idle_edn_req", 64'(bus_if.edn_req), 64'h0);
    tick();
    mon_g      = g;
    mon_active = 1'b1;
    if (drop) bus_if.req = reqv & ~2'(1 << g);
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < stall[k]; s++) begin
        check("stall_edn_req", 64'(bus_if.edn_req), 64'h1);
        check("stall_ack", 64'(bus_if.ack), 64'h0);
        tick();
      end
      bus_if.edn_ack = 1'b1;
      bus_if.edn_bus = w[k];
      check("word_edn_req", 64'(bus_if.edn_req), 64'h1);
      check("word_ack", 64'(bus_if.ack), 64'h0);
      tick();
      bus_if.edn_ack = 1'b0;
      bus_if.edn_bus = $urandom;
    end
    mon_active = 1'b0;
    check("ack", 64'(bus_if.ack), 64'(exp_ack));
    check("data", bus_if.data, exp_data);
    check("ack_edn_req", 64'(bus_if.edn_req), 64'h0);
    if (!hold_req) bus_if.req = bus_if.req & ~2'(1 << g);
    tick();
    check("post_ack", 64'(bus_if.ack), 64'h0);
    check("post_data", bus_if.data, 64'h0);
  endtask

  initial begin
    rst_i          = 1'b1;
    bus_if.req     = 2'b00;
    bus_if.edn_ack = 1'b0;
    bus_if.edn_bus = 32'h0;
    tick();
    tick();
    check("rst_ack", 64'(bus_if.ack), 64'h0);
    check("rst_data", bus_if.data, 64'h0);
    check("rst_edn_req", 64'(bus_if.edn_req), 64'h0);
    check("rst_fsm_err", 64'(fsm_err_o), 64'h0);
    rst_i = 1'b0;
    ptr   = 0;

    // Basic single request, EDN answering every cycle.
    run_txn(2'b01, 0, 0, 32'hA5A5_0001, 32'hA5A5_0002, 1'b0, 1'b0);

    // EDN ack while idle and not requested must be ignored.
    bus_if.edn_ack = 1'b1;
    bus_if.edn_bus = 32'hDEAD_DEAD;
    tick();
    bus_if.edn_ack = 1'b0;
    check("idle_ignore_edn_req", 64'(bus_if.edn_req), 64'h0);
    check("idle_ignore_ack", 64'(bus_if.ack), 64'h0);

    // Contention with both requests held: grants alternate.
    for (int i = 0; i < 4; i++)
      run_txn(2'b11, 0, 0, $urandom, $urandom, 1'b0, 1'b1);
    bus_if.req = 2'b00;

    // Long EDN stall between words.
    run_txn(2'b10, 0, 5, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
    check("no_violation_yet", 64'(viol_cnt), 64'h0);

    // Reset after the first word: partial data dropped, arbitration restarts.
    bus_if.req = 2'b01;
    tick();
    bus_if.edn_ack = 1'b1;
    bus_if.edn_bus = 32'hBAD0_BAD0;
    tick();
    bus_if.edn_ack = 1'b0;
    bus_if.req     = 2'b00;
    rst_i          = 1'b1;
    tick();
    rst_i = 1'b0;
    ptr   = 0;
    check("midrst_edn_req", 64'(bus_if.edn_req), 64'h0);
    check("midrst_ack", 64'(bus_if.ack), 64'h0);
    check("midrst_data", bus_if.data, 64'h0);
    tick();
    check("midrst_idle_ack", 64'(bus_if.ack), 64'h0);
    run_txn(2'b01, 0, 0, 32'hC0DE_0000, 32'hC0DE_0001, 1'b0, 1'b0);

    // Requestor 1 drops its request mid-gather: no ack, pointer still moves on.
    run_txn(2'b10, 1, 0, $urandom, $urandom, 1'b1, 1'b0);
    check("violation_flagged", 64'(viol_cnt > 0), 64'h1);
    run_txn(2'b11, 0, 0, $urandom, $urandom, 1'b0, 1'b0);
    viol_cnt = 0;

    // Randomized traffic.
    for (int i = 0; i < 16; i++) begin
      int gap;
      run_txn(2'($urandom_range(1, 3)), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
      bus_if.req = 2'b00;
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        bus_if.edn_ack = 1'($urandom_range(0, 1));
        bus_if.edn_bus = $urandom;
        tick();
        bus_if.edn_ack = 1'b0;
        check("gap_edn_req", 64'(bus_if.edn_req), 64'h0);
      end
    end
    check("rand_no_violation", 64'(viol_cnt), 64'h0);

    // Illegal state encoding traps into the terminal error state.
    force dut.state_q = edn_gather_state_e'(9'h000);
    #1;
    check("fault_err_comb", 64'(fsm_err_o), 64'h1);
    bus_if.req = 2'b11;
    tick();
    release dut.state_q;
    tick();
    check("fault_state", 64'(dut.state_q), 64'(ErrorSt));
    for (int i = 0; i < 8; i++) begin
      check("fault_err", 64'(fsm_err_o), 64'h1);
      check("fault_edn_req", 64'(bus_if.edn_req), 64'h0);
      check("fault_ack", 64'(bus_if.ack), 64'h0);
      check("fault_data", bus_if.data, 64'h0);
      bus_if.edn_ack = 1'($urandom_range(0, 1));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
